// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle plus the regfile write port, shared between the
// writeback sources (master) and regfile_write_arbiter (slave).
interface regfile_write_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [NREQ-1:0]        ReqValid;
  logic [NREQ*ADDR_W-1:0] ReqAddr;
  logic [NREQ*DATA_W-1:0] ReqData;
  logic [NREQ-1:0]        ReqReady;
  logic [ADDR_W-1:0]      WriteRegister;
  logic [DATA_W-1:0]      WriteData;
  logic                   RegWrite;

  modport master (
    output ReqValid, ReqAddr, ReqData,
    input  ReqReady, WriteRegister, WriteData, RegWrite
  );

  modport slave (
    input  ReqValid, ReqAddr, ReqData,
    output ReqReady, WriteRegister, WriteData, RegWrite
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins).
module regfile_write_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Hold,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   w_grant;
  logic [PTR_W-1:0]  w_grantIdx;
  logic              w_fire;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_regWrite;
  logic [ADDR_W-1:0] r_writeRegister;
  logic [DATA_W-1:0] r_writeData;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
`else
  logic [PTR_W-1:0]  r_ptr;
`endif

  // Circular search for the first valid requester; Reset and Hold mask all grants.
  always_comb begin
    int idx;
    w_grant    = '0;
    w_grantIdx = '0;
    w_fire     = 1'b0;
    idx        = 0;
    if (!Reset && !Hold) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (int'(r_ptr) + k) % NREQ;
`endif
        if (!w_fire && bus.ReqValid[idx]) begin
          w_fire       = 1'b1;
          w_grant[idx] = 1'b1;
          w_grantIdx   = PTR_W'(idx);
        end
      end
    end
  end

  assign w_addr = bus.ReqAddr[int'(w_grantIdx)*ADDR_W +: ADDR_W];
  assign w_data = bus.ReqData[int'(w_grantIdx)*DATA_W +: DATA_W];

`ifdef REGFILE_ARB_FIXED_PRIO_EN
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= (w_grantIdx == PTR_W'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;
    end
  end
`endif

  // Register-zero writes are consumed but leave RegWrite low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_regWrite      <= 1'b0;
      r_writeRegister <= '0;
      r_writeData     <= '0;
    end else if (w_fire) begin
      r_regWrite      <= (w_addr != '0);
      r_writeRegister <= w_addr;
      r_writeData     <= w_data;
    end else begin
      r_regWrite      <= 1'b0;
    end
  end

  assign bus.ReqReady      = w_grant;
  assign bus.RegWrite      = r_regWrite;
  assign bus.WriteRegister = r_writeRegister;
  assign bus.WriteData     = r_writeData;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=2) with a write scoreboard and
// a small regfile model fed by the arbiter's write port.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic Clk = 1'b0;
  logic Reset;
  logic Hold;

  regfile_write_arbiter_if #(.NREQ(2), .DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(.NREQ(2), .DATA_W(32), .ADDR_W(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Hold  (Hold),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  int          tbPtr  = 0;
  wr_t         sb[$];
  logic [4:0]  lastAddr = '0;
  logic [31:0] lastData = '0;
  logic [31:0] tbRegs [32];

  // Regfile model: captures whatever the port presents, register 0 hardwired to zero.
  always @(posedge Clk) begin
    if (bus.RegWrite === 1'b1 && bus.WriteRegister != 5'd0)
      tbRegs[bus.WriteRegister] <= bus.WriteData;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelGrant(input logic rst, input logic hold, input logic [1:0] valid);
    int start;
    if (rst || hold) return -1;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = tbPtr;
`endif
    for (int k = 0; k < 2; k++) begin
      if (valid[(start + k) % 2]) return (start + k) % 2;
    end
    return -1;
  endfunction

  task automatic checkOutput(input logic rst);
    wr_t e;
    if (rst) begin
      check("RstRegWrite", 64'(bus.RegWrite), 64'd0);
      check("RstWriteRegister", 64'(bus.WriteRegister), 64'd0);
      check("RstWriteData", 64'(bus.WriteData), 64'd0);
      lastAddr = '0;
      lastData = '0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      check("RegWrite", 64'(bus.RegWrite), 64'(e.addr != 5'd0));
      check("WriteRegister", 64'(bus.WriteRegister), 64'(e.addr));
      check("WriteData", 64'(bus.WriteData), 64'(e.data));
      lastAddr = e.addr;
      lastData = e.data;
    end else begin
      check("IdleRegWrite", 64'(bus.RegWrite), 64'd0);
      check("IdleWriteRegister", 64'(bus.WriteRegister), 64'(lastAddr));
      check("IdleWriteData", 64'(bus.WriteData), 64'(lastData));
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hold, input logic [1:0] valid,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               output int g);
    logic [1:0] expReady;
    wr_t e;
    Reset        = rst;
    Hold         = hold;
    bus.ReqValid = valid;
    bus.ReqAddr  = {a1, a0};
    bus.ReqData  = {d1, d0};
    #1;
    g        = modelGrant(rst, hold, valid);
    expReady = (g < 0) ? 2'b00 : (2'b01 << g);
    check("ReqReady", 64'(bus.ReqReady), 64'(expReady));
    if (g >= 0) begin
      e.addr = (g == 0) ? a0 : a1;
      e.data = (g == 0) ? d0 : d1;
      sb.push_back(e);
    end
    @(posedge Clk);
    if (rst) begin
      tbPtr = 0;
      sb.delete();
    end else if (g >= 0) begin
      tbPtr = (g + 1) % 2;
    end
    #1;
    checkOutput(rst);
  endtask

  initial begin
    int g;
    int expSeq [4];
    for (int r = 0; r < 32; r++) tbRegs[r] = '0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    expSeq = '{0, 0, 0, 0};
`else
    expSeq = '{0, 1, 0, 1};
`endif

    // Reset for two cycles with both requesters valid
    applyStimulus(1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'hA, 32'hB, g);
    applyStimulus(1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'hA, 32'hB, g);

    // Single request, then regfile readback one edge later
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, g);
    check("SingleGrant", 64'(g), 64'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, g);
    check("Reg3", 64'(tbRegs[3]), 64'hDEADBEEF);

    // Contention from reset: four consecutive grants, no bubbles
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, g);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b11, 5'd1, 5'd2, 32'hA, 32'hB, g);
      check("ContGrant", 64'(g), 64'(expSeq[i]));
    end

    // Register-zero request: consumed, RegWrite stays low
    applyStimulus(1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF, g);
    check("Reg0Grant", 64'(g), 64'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, g);

    // Hold for three cycles, then Reset as Hold drops, then the retained request
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, g);
    applyStimulus(1'b1, 1'b0, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, g);
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, g);
    check("HoldReleaseGrant", 64'(g), 64'd0);

    // Back-to-back writes to the same register: last grant wins
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd7, 5'd0, 32'd1, 32'h0, g);
    applyStimulus(1'b0, 1'b0, 2'b10, 5'd0, 5'd7, 32'h0, 32'd2, g);
    check("Reg7First", 64'(tbRegs[7]), 64'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, g);
    check("Reg7Last", 64'(tbRegs[7]), 64'd2);
    check("Reg9", 64'(tbRegs[9]), 64'h55);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
